pulse_indicator: RTL and testbench

//   Output-side counterpart to the button debouncer: turns one-cycle event pulses
//   (e.g. debounced presses, FSM strobes) into human-visible LED blinks.

---
 rtl/pulse_indicator.sv | 129 ++++++++++++
 tb/tb_pulse_indicator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_indicator.sv
// rtl/pulse_indicator.sv - turns one-cycle event strobes into visible LED blinks with a saturating replay queue
module pulse_indicator #(
   parameter int ON_CYCLES  = 25000000,
   parameter int OFF_CYCLES = 25000000,
   parameter int PEND_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse,
   input  logic              clear,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   // One timer serves both phases, so it is sized for the longer of the two.
   localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

   localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [TW-1:0]     TMR_ONE  = TW'(1);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     timer_nxt;
   logic [PEND_W-1:0] pending_nxt;
   logic              overflow_nxt;
   logic              enqueue;
   logic              dequeue;

   // Next-state, timer and queue bookkeeping; clear overrides everything, including a same-cycle pulse.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      pending_nxt  = pending;
      overflow_nxt = overflow;
      enqueue      = 1'b0;
      dequeue      = 1'b0;

      if (clear) begin
         state_nxt    = S_IDLE;
         timer_nxt    = '0;
         pending_nxt  = '0;
         overflow_nxt = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // A pulse in IDLE starts the blink directly and never touches the queue.
               if (pulse) begin
                  state_nxt = S_ON;
                  timer_nxt = ON_LOAD;
               end
            end
            S_ON: begin
               enqueue = pulse;
               if (timer != '0) begin
                  timer_nxt = timer - TMR_ONE;
               end else begin
                  state_nxt = S_GAP;
                  timer_nxt = OFF_LOAD;
               end
            end
            S_GAP: begin
               if (timer != '0) begin
                  timer_nxt = timer - TMR_ONE;
                  enqueue   = pulse;
               end else if (pending != '0) begin
                  // Replay a queued blink; a same-cycle pulse takes the freed slot.
                  state_nxt = S_ON;
                  timer_nxt = ON_LOAD;
                  dequeue   = 1'b1;
                  enqueue   = pulse;
               end else if (pulse) begin
                  // Empty queue: the pulse itself restarts the blink, so it is not queued.
                  state_nxt = S_ON;
                  timer_nxt = ON_LOAD;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               timer_nxt = '0;
            end
         endcase

         if (enqueue && !dequeue) begin
            if (pending == PEND_MAX) begin
               overflow_nxt = 1'b1;
            end else begin
               pending_nxt = pending + PEND_ONE;
            end
         end else if (dequeue && !enqueue) begin
            pending_nxt = pending - PEND_ONE;
         end
      end
   end

   // State, timer and queue registers; outputs are registered from the next state so led tracks ON exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         timer    <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         led      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         pending  <= pending_nxt;
         overflow <= overflow_nxt;
         led      <= (state_nxt == S_ON);
         busy     <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_pulse_indicator.sv
// tb/tb_pulse_indicator.sv - directed-vector bench for pulse_indicator (ON=4, OFF=3, PEND_W=2)
module tb_pulse_indicator;

   logic       clk;
   logic       rst_n;
   logic       pulse;
   logic       clear;
   logic       led;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int vectors;
   int miscompares;

   pulse_indicator #(
      .ON_CYCLES (4),
      .OFF_CYCLES(3),
      .PEND_W    (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pulse   (pulse),
      .clear   (clear),
      .led     (led),
      .busy    (busy),
      .pending (pending),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hold reset across two edges and release on a falling edge, so the next rising edge is cycle 1.
   task automatic do_reset();
      rst_n = 1'b0;
      pulse = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pulse = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (led !== 1'b0) begin miscompares++; $display("FAIL reset_led got %b exp 0", led); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
      vectors++;
      if (pending !== 2'd0) begin miscompares++; $display("FAIL reset_pending got %0d exp 0", pending); end
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic e_led, e_busy;
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         pulse = (c == 10);
         @(negedge clk);
         e_led  = (c >= 11 && c <= 14);
         e_busy = (c >= 11 && c <= 17);
         vectors++;
         if (led !== e_led) begin miscompares++; $display("FAIL single_led c=%0d got %b exp %b", c, led, e_led); end
         vectors++;
         if (busy !== e_busy) begin miscompares++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, e_busy); end
         vectors++;
         if (pending !== 2'd0) begin miscompares++; $display("FAIL single_pending c=%0d got %0d exp 0", c, pending); end
      end
      pulse = 1'b0;
   endtask

   task automatic test_queue();
      logic       e_led, e_busy;
      logic [1:0] e_pend;
      do_reset();
      for (int c = 1; c <= 33; c++) begin
         @(posedge clk); #1;
         pulse = (c == 10 || c == 12 || c == 13);
         @(negedge clk);
         e_led  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
         e_busy = (c >= 11 && c <= 31);
         if (c == 13)                 e_pend = 2'd1;
         else if (c >= 14 && c <= 17) e_pend = 2'd2;
         else if (c >= 18 && c <= 24) e_pend = 2'd1;
         else                         e_pend = 2'd0;
         vectors++;
         if (led !== e_led) begin miscompares++; $display("FAIL queue_led c=%0d got %b exp %b", c, led, e_led); end
         vectors++;
         if (busy !== e_busy) begin miscompares++; $display("FAIL queue_busy c=%0d got %b exp %b", c, busy, e_busy); end
         vectors++;
         if (pending !== e_pend) begin miscompares++; $display("FAIL queue_pending c=%0d got %0d exp %0d", c, pending, e_pend); end
      end
      pulse = 1'b0;
   endtask

   task automatic test_saturate();
      logic       e_led, e_busy, e_ovf, prev_led;
      logic [1:0] e_pend;
      int         blinks;
      blinks   = 0;
      prev_led = 1'b0;
      do_reset();
      for (int c = 1; c <= 42; c++) begin
         @(posedge clk); #1;
         pulse = (c >= 10 && c <= 14);
         @(negedge clk);
         e_led  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28) || (c >= 32 && c <= 35);
         e_busy = (c >= 11 && c <= 38);
         e_ovf  = (c >= 15);
         if (c == 12)                 e_pend = 2'd1;
         else if (c == 13)            e_pend = 2'd2;
         else if (c >= 14 && c <= 17) e_pend = 2'd3;
         else if (c >= 18 && c <= 24) e_pend = 2'd2;
         else if (c >= 25 && c <= 31) e_pend = 2'd1;
         else                         e_pend = 2'd0;
         if (led && !prev_led) blinks++;
         prev_led = led;
         vectors++;
         if (led !== e_led) begin miscompares++; $display("FAIL sat_led c=%0d got %b exp %b", c, led, e_led); end
         vectors++;
         if (busy !== e_busy) begin miscompares++; $display("FAIL sat_busy c=%0d got %b exp %b", c, busy, e_busy); end
         vectors++;
         if (pending !== e_pend) begin miscompares++; $display("FAIL sat_pending c=%0d got %0d exp %0d", c, pending, e_pend); end
         vectors++;
         if (overflow !== e_ovf) begin miscompares++; $display("FAIL sat_overflow c=%0d got %b exp %b", c, overflow, e_ovf); end
      end
      pulse = 1'b0;
      vectors++;
      if (blinks != 4) begin miscompares++; $display("FAIL sat_blink_count got %0d exp 4", blinks); end
   endtask

   task automatic test_back_to_back();
      logic e_led, e_busy;
      do_reset();
      for (int c = 1; c <= 26; c++) begin
         @(posedge clk); #1;
         pulse = (c == 10 || c == 17);
         @(negedge clk);
         e_led  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21);
         e_busy = (c >= 11 && c <= 24);
         vectors++;
         if (led !== e_led) begin miscompares++; $display("FAIL b2b_led c=%0d got %b exp %b", c, led, e_led); end
         vectors++;
         if (busy !== e_busy) begin miscompares++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, e_busy); end
         vectors++;
         if (pending !== 2'd0) begin miscompares++; $display("FAIL b2b_pending c=%0d got %0d exp 0", c, pending); end
      end
      pulse = 1'b0;
   endtask

   task automatic test_clear();
      logic       e_led, e_busy, e_ovf;
      logic [1:0] e_pend;
      do_reset();
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         pulse = (c >= 10 && c <= 14) || (c == 19) || (c == 23);
         clear = (c == 19);
         @(negedge clk);
         e_led  = (c >= 11 && c <= 14) || (c >= 18 && c <= 19) || (c >= 24 && c <= 27);
         e_busy = (c >= 11 && c <= 19) || (c >= 24);
         e_ovf  = (c >= 15 && c <= 19);
         if (c == 12)                 e_pend = 2'd1;
         else if (c == 13)            e_pend = 2'd2;
         else if (c >= 14 && c <= 17) e_pend = 2'd3;
         else if (c >= 18 && c <= 19) e_pend = 2'd2;
         else                         e_pend = 2'd0;
         vectors++;
         if (led !== e_led) begin miscompares++; $display("FAIL clear_led c=%0d got %b exp %b", c, led, e_led); end
         vectors++;
         if (busy !== e_busy) begin miscompares++; $display("FAIL clear_busy c=%0d got %b exp %b", c, busy, e_busy); end
         vectors++;
         if (pending !== e_pend) begin miscompares++; $display("FAIL clear_pending c=%0d got %0d exp %0d", c, pending, e_pend); end
         vectors++;
         if (overflow !== e_ovf) begin miscompares++; $display("FAIL clear_overflow c=%0d got %b exp %b", c, overflow, e_ovf); end
      end
      pulse = 1'b0;
      clear = 1'b0;
   endtask

   task automatic test_reset_mid_blink();
      logic e_led;
      do_reset();
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         pulse = (c == 10);
      end
      @(posedge clk); #1;
      pulse = 1'b0;
      vectors++;
      if (led !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_led got %b exp 1", led); end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (led !== 1'b0) begin miscompares++; $display("FAIL midrst_led got %b exp 0", led); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b exp 0", busy); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         pulse = (c == 15);
         @(negedge clk);
         e_led = (c >= 16 && c <= 19);
         vectors++;
         if (led !== e_led) begin miscompares++; $display("FAIL midrst_after_led c=%0d got %b exp %b", c, led, e_led); end
         vectors++;
         if (pending !== 2'd0) begin miscompares++; $display("FAIL midrst_after_pending c=%0d got %0d exp 0", c, pending); end
      end
      pulse = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      pulse       = 1'b0;
      clear       = 1'b0;
      test_reset();
      test_single();
      test_queue();
      test_saturate();
      test_back_to_back();
      test_clear();
      test_reset_mid_blink();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
